// File: rtl/display_bank_if.sv
// display_bank_if: command inputs, segment pins and status for display_bank.
// master = command source / pin observer, slave = display_bank itself.
interface display_bank_if #(
   parameter int NDIG = 8
);
   logic            wr_en;
   logic [1:0]      mode;
   logic [3:0]      dig;
   logic [3:0]      pos;
   logic            lz_en;
   logic            dp_en;
   logic [3:0]      dp_pos;
   logic [NDIG-1:0] blink_mask;
   logic [NDIG-1:0] a, b, c, d, e, f, g, dp;
   logic [4:0]      count;
   logic            ovf;

   modport master (
      output wr_en, mode, dig, pos, lz_en, dp_en, dp_pos, blink_mask,
      input  a, b, c, d, e, f, g, dp, count, ovf
   );

   modport slave (
      input  wr_en, mode, dig, pos, lz_en, dp_en, dp_pos, blink_mask,
      output a, b, c, d, e, f, g, dp, count, ovf
   );
endinterface

// File: rtl/display_bank.sv
// display_bank: NDIG-digit seven-segment bank with write / insert / clear /
// backspace entry, leading-zero suppression, decimal point and a registered
// active-low decode stage. Optional blinking is built when DISPLAY_BLINK_EN
// is defined.
module display_bank #(
   parameter int NDIG      = 8,
   parameter int BLINK_DIV = 25_000_000
) (
   input logic           clock,
   input logic           reset,
   display_bank_if.slave bus
);

   localparam logic [3:0] BLANK = 4'd15;
   localparam logic [4:0] NDIG5 = 5'(NDIG);

   logic [NDIG-1:0][3:0] data_q, data_d;
   logic [4:0]           count_q, count_d;
   logic                 ovf_q, ovf_d;
   logic [NDIG-1:0][7:0] seg_q, seg_d;      // {dp,g,f,e,d,c,b,a}, active low
   logic [NDIG-1:0]      blink_dark;        // digits forced dark this cycle

   // Active-high gfedcba pattern; codes 11..15 are dark.
   function automatic logic [6:0] decode(input logic [3:0] code);
      case (code)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         4'd10:   decode = 7'h40;
         default: decode = 7'h00;
      endcase
   endfunction

   // Command decode: at most one edit of the digit store per cycle.
   always_comb begin
      data_d  = data_q;
      count_d = count_q;
      ovf_d   = 1'b0;
      if (bus.wr_en) begin
         case (bus.mode)
            2'b00: begin
               // Out-of-range positions simply match no digit.
               for (int i = 0; i < NDIG; i++)
                  if ({1'b0, bus.pos} == 5'(i))
                     data_d[i] = (bus.dig > 4'd10) ? BLANK : bus.dig;
            end
            2'b01: begin
               if (bus.dig <= 4'd9) begin
                  if (count_q < NDIG5) begin
                     data_d  = {data_q[NDIG-2:0], bus.dig};
                     count_d = count_q + 5'd1;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
            end
            2'b10: begin
               data_d  = {NDIG{BLANK}};
               count_d = 5'd0;
            end
            default: begin
               if (count_q != 5'd0) begin
                  data_d  = {BLANK, data_q[NDIG-1:1]};
                  count_d = count_q - 5'd1;
               end
            end
         endcase
      end
   end

`ifdef DISPLAY_BLINK_EN
   localparam int DW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   logic [DW-1:0] div_q, div_d;
   logic          phase_q, phase_d;   // 1 = on phase

   // Free-running divider; the blink phase flips each time it wraps.
   always_comb begin
      div_d   = div_q + DW'(1);
      phase_d = phase_q;
      if (div_q == DW'(BLINK_DIV - 1)) begin
         div_d   = '0;
         phase_d = ~phase_q;
      end
   end

   // Divider and phase registers; reset starts in the on phase.
   always_ff @(posedge clock) begin
      if (reset) begin
         div_q   <= '0;
         phase_q <= 1'b1;
      end else begin
         div_q   <= div_d;
         phase_q <= phase_d;
      end
   end

   assign blink_dark = phase_q ? '0 : bus.blink_mask;
`else
   logic unused_blink;
   assign unused_blink = ^bus.blink_mask;
   assign blink_dark   = '0;
`endif

   // Pin image: scan from the top digit to know whether everything above is blank/zero.
   always_comb begin
      logic       above_blank;
      logic       suppress;
      logic       dp_lit;
      logic [3:0] code;
      seg_d       = '1;
      above_blank = 1'b1;
      suppress    = 1'b0;
      dp_lit      = 1'b0;
      code        = '0;
      for (int i = NDIG - 1; i >= 0; i--) begin
         code        = data_q[i];
         suppress    = bus.lz_en && (i > 0) && (code == 4'd0) && above_blank;
         above_blank = above_blank && ((code == 4'd0) || (code == BLANK));
         dp_lit      = bus.dp_en && ({1'b0, bus.dp_pos} == 5'(i));
         seg_d[i]    = ~{dp_lit, suppress ? 7'd0 : decode(code)};
         if (blink_dark[i])
            seg_d[i] = 8'hFF;
      end
   end

   // State and pin registers; reset blanks the store and darkens every digit.
   always_ff @(posedge clock) begin
      if (reset) begin
         data_q  <= {NDIG{BLANK}};
         count_q <= 5'd0;
         ovf_q   <= 1'b0;
         seg_q   <= '1;
      end else begin
         data_q  <= data_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         seg_q   <= seg_d;
      end
   end

   // Fan the registered pin image out to the per-segment vectors.
   always_comb begin
      bus.a  = '1;
      bus.b  = '1;
      bus.c  = '1;
      bus.d  = '1;
      bus.e  = '1;
      bus.f  = '1;
      bus.g  = '1;
      bus.dp = '1;
      for (int i = 0; i < NDIG; i++) begin
         bus.a[i]  = seg_q[i][0];
         bus.b[i]  = seg_q[i][1];
         bus.c[i]  = seg_q[i][2];
         bus.d[i]  = seg_q[i][3];
         bus.e[i]  = seg_q[i][4];
         bus.f[i]  = seg_q[i][5];
         bus.g[i]  = seg_q[i][6];
         bus.dp[i] = seg_q[i][7];
      end
   end

   assign bus.count = count_q;
   assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_display_bank.sv
// tb_display_bank: randomized and directed checks of display_bank against a
// queue-based model of the digit store and a segment-letter decode table.
module tb_display_bank;
   localparam int NDIG = 8;
   localparam int BDIV = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   display_bank_if #(.NDIG(NDIG)) bus ();
   display_bank #(.NDIG(NDIG), .BLINK_DIV(BDIV)) dut (.clock(clock), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;

   // Model: digit store as a queue (index 0 = rightmost), entry count, ovf.
   int  mdl[$];
   int  mcnt;
   bit  movf;
   int  blink_cnt;
   logic [NDIG-1:0][7:0] exp_seg;

   // Lit segments per code, by letter.
   string lit[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                      "abcdefg", "abcdfg", "g", "", "", "", "", ""};

   function automatic logic [7:0] model_digit(int i);
      int lead = -1;
      logic [7:0] s = 8'hFF;
      string str;
      for (int j = 0; j < NDIG; j++)
         if (mdl[j] != 0 && mdl[j] != 15) lead = j;
      if (!(bus.lz_en && i > 0 && mdl[i] == 0 && i > lead)) begin
         str = lit[mdl[i]];
         for (int k = 0; k < str.len(); k++) s[int'(str[k]) - 97] = 1'b0;
      end
      if (bus.dp_en && int'(bus.dp_pos) == i) s[7] = 1'b0;
`ifdef DISPLAY_BLINK_EN
      if (bus.blink_mask[i] && ((blink_cnt / BDIV) % 2 == 1)) s = 8'hFF;
`endif
      return s;
   endfunction

   function automatic logic [NDIG-1:0][7:0] pins();
      logic [NDIG-1:0][7:0] r;
      for (int i = 0; i < NDIG; i++)
         r[i] = {bus.dp[i], bus.g[i], bus.f[i], bus.e[i], bus.d[i], bus.c[i], bus.b[i], bus.a[i]};
      return r;
   endfunction

   task automatic drive(input bit w, input int m, input int dg, input int p);
      bus.wr_en = w;
      bus.mode  = 2'(m);
      bus.dig   = 4'(dg);
      bus.pos   = 4'(p);
   endtask

   // One clock edge: advance the model with the inputs present at the edge.
   task automatic tick();
      @(posedge clock);
      if (reset) begin
         exp_seg = '1;
         mdl = {};
         repeat (NDIG) mdl.push_back(15);
         mcnt = 0;
         movf = 1'b0;
         blink_cnt = 0;
      end else begin
         for (int i = 0; i < NDIG; i++) exp_seg[i] = model_digit(i);
         blink_cnt++;
         movf = 1'b0;
         if (bus.wr_en) begin
            case (bus.mode)
               2'd0: if (int'(bus.pos) < NDIG) mdl[bus.pos] = (bus.dig > 10) ? 15 : int'(bus.dig);
               2'd1: if (bus.dig <= 9) begin
                  if (mcnt < NDIG) begin
                     mdl.push_front(int'(bus.dig));
                     void'(mdl.pop_back());
                     mcnt++;
                  end else movf = 1'b1;
               end
               2'd2: begin
                  foreach (mdl[k]) mdl[k] = 15;
                  mcnt = 0;
               end
               default: if (mcnt > 0) begin
                  void'(mdl.pop_front());
                  mdl.push_back(15);
                  mcnt--;
               end
            endcase
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0);
      tick(); tick();
      reset = 1'b0;
      tick(); tick();
      checks++; if (pins() !== {NDIG{8'hFF}}) begin errors++; $display("FAIL reset_segs got %h want %h", pins(), {NDIG{8'hFF}}); end
      checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
      checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
   endtask

   task automatic test_insert();
      for (int d = 1; d <= 3; d++) begin
         drive(1, 1, d, 0);
         tick();
         checks++; if (bus.count !== 5'(d)) begin errors++; $display("FAIL insert_count got %0d want %0d", bus.count, d); end
         checks++; if (pins() !== exp_seg) begin errors++; $display("FAIL insert_lag got %h want %h", pins(), exp_seg); end
      end
      drive(0, 0, 0, 0);
      tick();
      checks++; if (pins() !== exp_seg) begin errors++; $display("FAIL insert_segs got %h want %h", pins(), exp_seg); end
      checks++; if (pins()[0] !== 8'hB0) begin errors++; $display("FAIL insert_digit0 got %h want b0", pins()[0]); end
   endtask

   task automatic test_overflow();
      drive(1, 1, 9, 0);
      while (mcnt < NDIG) tick();
      checks++; if (bus.count !== 5'(NDIG)) begin errors++; $display("FAIL full_count got %0d want %0d", bus.count, NDIG); end
      checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL full_ovf got %b want 0", bus.ovf); end
      tick();
      checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b want 1", bus.ovf); end
      tick();
      checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_hold got %b want 1", bus.ovf); end
      checks++; if (bus.count !== 5'(NDIG)) begin errors++; $display("FAIL ovf_count got %0d want %0d", bus.count, NDIG); end
      drive(0, 0, 0, 0);
      tick();
      checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_drop got %b want 0", bus.ovf); end
      checks++; if (pins() !== exp_seg) begin errors++; $display("FAIL ovf_data got %h want %h", pins(), exp_seg); end
      drive(1, 3, 0, 0);
      tick();
      checks++; if (bus.count !== 5'(NDIG - 1)) begin errors++; $display("FAIL bksp_count got %0d want %0d", bus.count, NDIG - 1); end
      drive(0, 0, 0, 0);
      tick();
      checks++; if (pins()[NDIG-1] !== 8'hFF) begin errors++; $display("FAIL bksp_top got %h want ff", pins()[NDIG-1]); end
      checks++; if (pins() !== exp_seg) begin errors++; $display("FAIL bksp_segs got %h want %h", pins(), exp_seg); end
   endtask

   task automatic test_write_lz();
      drive(1, 2, 0, 0); tick();
      checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL clear_count got %0d want 0", bus.count); end
      bus.lz_en = 1'b1;
      drive(1, 0, 0, 7); tick();
      drive(1, 0, 0, 6); tick();
      drive(1, 0, 5, 0); tick();
      drive(0, 0, 0, 0); tick();
      checks++; if (pins()[7] !== 8'hFF || pins()[6] !== 8'hFF) begin errors++; $display("FAIL lz_dark got %h_%h want ff_ff", pins()[7], pins()[6]); end
      checks++; if (pins()[0] !== 8'h92) begin errors++; $display("FAIL lz_digit0 got %h want 92", pins()[0]); end
      bus.lz_en = 1'b0;
      tick();
      checks++; if (pins()[7] !== 8'hC0 || pins()[6] !== 8'hC0) begin errors++; $display("FAIL lz_off got %h_%h want c0_c0", pins()[7], pins()[6]); end
      checks++; if (pins() !== exp_seg) begin errors++; $display("FAIL lz_segs got %h want %h", pins(), exp_seg); end
   endtask

   task automatic test_write_misc();
      drive(1, 0, 4, 9); tick();
      drive(1, 0, 10, 3); tick();
      drive(1, 0, 12, 0); tick();
      drive(0, 0, 0, 0); tick();
      checks++; if (pins()[3] !== 8'hBF) begin errors++; $display("FAIL minus got %h want bf", pins()[3]); end
      checks++; if (pins()[0] !== 8'hFF) begin errors++; $display("FAIL blank_code got %h want ff", pins()[0]); end
      checks++; if (pins() !== exp_seg) begin errors++; $display("FAIL write_oob got %h want %h", pins(), exp_seg); end
      bus.dp_en = 1'b1; bus.dp_pos = 4'd3;
      tick();
      checks++; if (bus.dp !== 8'hF7) begin errors++; $display("FAIL dp_pos3 got %h want f7", bus.dp); end
      bus.dp_pos = 4'd9;
      tick();
      checks++; if (bus.dp !== 8'hFF) begin errors++; $display("FAIL dp_oob got %h want ff", bus.dp); end
      bus.dp_en = 1'b0;
   endtask

   task automatic test_reset_priority();
      drive(1, 1, 5, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(0, 0, 0, 0);
      checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL rst_prio_count got %0d want 0", bus.count); end
      tick();
      checks++; if (pins() !== {NDIG{8'hFF}}) begin errors++; $display("FAIL rst_prio_segs got %h want all ff", pins()); end
   endtask

   task automatic test_random();
      int r;
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         drive(($urandom_range(0, 3) != 0), (r < 45) ? 1 : (r < 70) ? 0 : (r < 90) ? 3 : 2,
               $urandom_range(0, 15), $urandom_range(0, 15));
         bus.lz_en      = 1'($urandom_range(0, 1));
         bus.dp_en      = 1'($urandom_range(0, 1));
         bus.dp_pos     = 4'($urandom_range(0, 15));
         bus.blink_mask = NDIG'($urandom);
         tick();
         checks++; if (bus.count !== 5'(mcnt)) begin errors++; $display("FAIL rnd_count @%0d got %0d want %0d", n, bus.count, mcnt); end
         checks++; if (bus.ovf !== movf) begin errors++; $display("FAIL rnd_ovf @%0d got %b want %b", n, bus.ovf, movf); end
         checks++; if (pins() !== exp_seg) begin errors++; $display("FAIL rnd_segs @%0d got %h want %h", n, pins(), exp_seg); end
      end
      drive(0, 0, 0, 0);
      bus.blink_mask = '0;
   endtask

   // Digit 0 holds 8 and blinks; a reset in the off phase returns it to on.
   task automatic test_blink();
      reset = 1'b1; tick(); reset = 1'b0;
      bus.blink_mask = 8'h01;
      bus.lz_en = 1'b0;
      bus.dp_en = 1'b0;
      drive(1, 1, 8, 0); tick();
      drive(0, 0, 0, 0);
      for (int n = 0; n < 4 * BDIV + 2; n++) begin
         tick();
         checks++; if (pins() !== exp_seg) begin errors++; $display("FAIL blink @%0d got %h want %h", n, pins(), exp_seg); end
      end
      reset = 1'b1; tick(); reset = 1'b0;
      drive(1, 1, 8, 0); tick();
      drive(0, 0, 0, 0); tick();
      checks++; if (pins()[0] !== 8'h80) begin errors++; $display("FAIL blink_rst got %h want 80", pins()[0]); end
      for (int n = 0; n < 2 * BDIV; n++) begin
         tick();
         checks++; if (pins() !== exp_seg) begin errors++; $display("FAIL blink2 @%0d got %h want %h", n, pins(), exp_seg); end
      end
      bus.blink_mask = '0;
   endtask

   initial begin
      drive(0, 0, 0, 0);
      bus.lz_en = 1'b0;
      bus.dp_en = 1'b0;
      bus.dp_pos = 4'd0;
      bus.blink_mask = '0;
      test_reset();
      test_insert();
      test_overflow();
      test_write_lz();
      test_write_misc();
      test_reset_priority();
      test_random();
      test_blink();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end
endmodule
